vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (visible px/line), H_FP 16 (h front porch), H_SYNC 96 (h sync px), H_BP 48 (h back porch).
REQ-002 SHALL have parameters: V_ACTIVE 480 (visible lines), V_FP 10, V_SYNC 2, V_BP 33 (v porch/sync lines).
REQ-003 SHALL have parameters: HS_POL 0 / VS_POL 0 (sync active level), COLOR_W 8 (bits/channel), RD_LAT 1 (pixel-source latency, legal 1..4).
REQ-004 SHALL derive H_TOTAL = sum of H_*, V_TOTAL = sum of V_*, CW = $clog2(H_ACTIVE), RW = $clog2(V_ACTIVE); counters sized $clog2(H_TOTAL), $clog2(V_TOTAL).
REQ-005 SHALL have ports: vga_clk in 1 (pixel clock); clr in 1 (asynchronous active-high reset); clock and reset are one clock domain, reset asynchronous active-high.
REQ-006 SHALL have ports: en in 1 (count enable); pix_data in 3*COLOR_W ({r,g,b}); pix_valid in 1 (source data valid); err_clr in 1 (clears underflow).
REQ-007 SHALL have ports: rd_en out 1 (pixel request); col_addr out CW; row_addr out RW (requested pixel coordinate).
REQ-008 SHALL have ports: r, g, b out COLOR_W each; hsync_out, vsync_out out 1; vga_blank_n out 1; vga_sync_n out 1 (tied 0).
REQ-009 SHALL have ports: frame_start out 1, line_start out 1 (one-cycle pulses, pin-aligned); underflow out 1 (sticky).

Function
REQ-010 h_count SHALL run 0..H_TOTAL-1 and wrap to 0; v_count SHALL increment only on h wrap, run 0..V_TOTAL-1 and wrap to 0.
REQ-011 Region order per line: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch; vertical identical in lines.
REQ-012 active = (h_count < H_ACTIVE) && (v_count < V_ACTIVE); hs = h in sync window; vs = v in sync window (whole lines).
REQ-013 Stage A: rd_en, col_addr = h_count, row_addr = v_count SHALL be registered one cycle after counter state; col/row_addr SHALL hold 0 when not active; rd_en = registered active.
REQ-014 Source returns pix_data/pix_valid exactly RD_LAT cycles after rd_en; block SHALL register them into r,g,b on the next edge.
REQ-015 active, hs, vs, h==0, (h==0&&v==0) SHALL pass through a delay pipe of RD_LAT+1 stages so all pin outputs align with r,g,b; counter-to-pin latency = RD_LAT+2 cycles.
REQ-016 hsync_out = HS_POL when delayed hs, else ~HS_POL; vsync_out likewise with VS_POL.
REQ-017 vga_blank_n = delayed active; r,g,b SHALL be 0 whenever delayed active is 0.
REQ-018 Delayed active=1 and pix_valid=0: r,g,b SHALL be 0 that cycle and underflow SHALL set on the next edge.
REQ-019 underflow SHALL stay 1 until err_clr=1 sampled; err_clr coincident with new underflow event: set wins.
REQ-020 line_start SHALL pulse for delayed h==0 on every line incl. blanking lines; frame_start for delayed h==0&&v==0, once per V_TOTAL*H_TOTAL cycles.
REQ-021 en=0 SHALL freeze counters, stage A and delay pipe (all outputs hold); en=1 resumes without skipped or repeated pixels.
REQ-022 RD_LAT outside 1..4 or any timing parameter 0 SHALL be a elaboration error.

Reset
REQ-023 clr=1 SHALL asynchronously force h_count=v_count=0, rd_en=0, col_addr=row_addr=0, pipe cleared to inactive.
REQ-024 During/after reset outputs SHALL be: r=g=b=0, hsync_out=~HS_POL, vsync_out=~VS_POL, vga_blank_n=0, frame_start=line_start=0, underflow=0, vga_sync_n=0.
REQ-025 First counter state after clr release SHALL be (0,0); frame_start first pulses RD_LAT+2 cycles after first enabled edge.

Verification
REQ-026 Defaults, en=1, pix_valid=1: hsync_out period 800 cycles, low 96 cycles, falling 656+3 cycles after reset release; blank_n high 640 cycles/line.
REQ-027 Defaults: vsync_out low for 2 lines (1600 cycles) starting line 490; frame_start period 420000 cycles; 480 lines with blank_n activity per frame.
REQ-028 Source echoes {r,g,b} = {col[7:0],row[7:0],8'h5A} with RD_LAT=3: pin rgb matches coordinate with blank_n=1, total latency 5 cycles.
REQ-029 Drop pix_valid for one active pixel: that pixel rgb=0, underflow=1 next cycle, held; err_clr pulse -> 0; drop in blanking -> no underflow.
REQ-030 Assert clr mid-line (h=300,v=100) -> outputs at reset values same cycle; after release frame restarts at (0,0); en=0 for 10 cycles -> all outputs held, line period becomes 810.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a latency-matched pixel fetch path.
// Counters request pixels one stage early; sync, blank and marker pulses are delayed to line up with the returned colour.
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOR_W  = 8,
  parameter int   RD_LAT   = 1,
  localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  CW       = $clog2(H_ACTIVE),
  localparam int  RW       = $clog2(V_ACTIVE)
) (
  input  logic                 vga_clk,
  input  logic                 clr,
  input  logic                 en,
  input  logic [3*COLOR_W-1:0] pix_data,
  input  logic                 pix_valid,
  input  logic                 err_clr,
  output logic                 rd_en,
  output logic [CW-1:0]        col_addr,
  output logic [RW-1:0]        row_addr,
  output logic [COLOR_W-1:0]   r,
  output logic [COLOR_W-1:0]   g,
  output logic [COLOR_W-1:0]   b,
  output logic                 hsync_out,
  output logic                 vsync_out,
  output logic                 vga_blank_n,
  output logic                 vga_sync_n,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 underflow
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  if (RD_LAT < 1 || RD_LAT > 4 ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
    $error("vga_timing_gen: RD_LAT must be 1..4 and every timing parameter non-zero");
  end

  logic [HW-1:0] r_h_count;
  logic [VW-1:0] r_v_count;
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic          w_h0;
  logic          w_f0;
  logic [4:0]    w_tap;

  logic          r_rd_en;
  logic [CW-1:0] r_col_addr;
  logic [RW-1:0] r_row_addr;

  // Each pipe entry is {active, hs, vs, h==0, h==0&&v==0}; all-zero means inactive.
  logic [RD_LAT:0][4:0] r_pipe;
  logic [4:0]           w_dly;
  logic                 w_dly_active;
  logic                 w_dly_hs;
  logic                 w_dly_vs;
  logic                 w_dly_h0;
  logic                 w_dly_f0;

  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (en) begin
      if (r_h_count == H_LAST) begin
        r_h_count <= '0;
        r_v_count <= (r_v_count == V_LAST) ? '0 : r_v_count + VW'(1);
      end else begin
        r_h_count <= r_h_count + HW'(1);
      end
    end
  end

  assign w_active = (r_h_count < H_ACT_END) && (r_v_count < V_ACT_END);
  assign w_hs     = (r_h_count >= HS_BEG) && (r_h_count < HS_END);
  assign w_vs     = (r_v_count >= VS_BEG) && (r_v_count < VS_END);
  assign w_h0     = (r_h_count == '0);
  assign w_f0     = w_h0 && (r_v_count == '0);
  assign w_tap    = {w_active, w_hs, w_vs, w_h0, w_f0};

  // Addresses park at zero outside the visible window so the source sees a quiet bus.
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_rd_en    <= 1'b0;
      r_col_addr <= '0;
      r_row_addr <= '0;
    end else if (en) begin
      r_rd_en    <= w_active;
      r_col_addr <= w_active ? r_h_count[CW-1:0] : '0;
      r_row_addr <= w_active ? r_v_count[RW-1:0] : '0;
    end
  end

  assign rd_en    = r_rd_en;
  assign col_addr = r_col_addr;
  assign row_addr = r_row_addr;

  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r_pipe <= '0;
    end else if (en) begin
      r_pipe <= {r_pipe[RD_LAT-1:0], w_tap};
    end
  end

  assign w_dly        = r_pipe[RD_LAT];
  assign w_dly_active = w_dly[4];
  assign w_dly_hs     = w_dly[3];
  assign w_dly_vs     = w_dly[2];
  assign w_dly_h0     = w_dly[1];
  assign w_dly_f0     = w_dly[0];

  // Pin stage: colour and control are captured on the same edge so they leave the chip aligned.
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      hsync_out   <= ~HS_POL;
      vsync_out   <= ~VS_POL;
      vga_blank_n <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (en) begin
      if (w_dly_active && pix_valid) begin
        r <= pix_data[3*COLOR_W-1:2*COLOR_W];
        g <= pix_data[2*COLOR_W-1:COLOR_W];
        b <= pix_data[COLOR_W-1:0];
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
      hsync_out   <= w_dly_hs ? HS_POL : ~HS_POL;
      vsync_out   <= w_dly_vs ? VS_POL : ~VS_POL;
      vga_blank_n <= w_dly_active;
      frame_start <= w_dly_f0;
      line_start  <= w_dly_h0;
    end
  end

  // A missing pixel inside the visible window sets the flag; a new miss beats a simultaneous clear.
  always_ff @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      underflow <= 1'b0;
    end else if (en && w_dly_active && !pix_valid) begin
      underflow <= 1'b1;
    end else if (err_clr) begin
      underflow <= 1'b0;
    end
  end

  assign vga_sync_n = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised scoreboard bench for vga_timing_gen using a small raster and RD_LAT=3.
// Expected pin values come from raster position arithmetic over enabled cycles since reset.
module tb_vga_timing_gen;

  localparam int   HA  = 16;
  localparam int   HF  = 4;
  localparam int   HSY = 6;
  localparam int   HB  = 5;
  localparam int   VA  = 8;
  localparam int   VF  = 2;
  localparam int   VSY = 3;
  localparam int   VB  = 2;
  localparam int   LAT = 3;
  localparam int   CWD = 8;
  localparam int   HT  = HA + HF + HSY + HB;
  localparam int   VT  = VA + VF + VSY + VB;
  localparam logic HSP = 1'b0;
  localparam logic VSP = 1'b1;
  localparam int   CWA = $clog2(HA);
  localparam int   RWA = $clog2(VA);

  logic                 vga_clk = 1'b0;
  logic                 clr = 1'b1;
  logic                 en = 1'b0;
  logic                 pix_valid = 1'b0;
  logic                 err_clr = 1'b0;
  logic [3*CWD-1:0]     pix_data;
  logic                 rd_en;
  logic [CWA-1:0]       col_addr;
  logic [RWA-1:0]       row_addr;
  logic [CWD-1:0]       r, g, b;
  logic                 hsync_out, vsync_out, vga_blank_n, vga_sync_n;
  logic                 frame_start, line_start, underflow;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP), .COLOR_W(CWD), .RD_LAT(LAT)
  ) dut (
    .vga_clk(vga_clk), .clr(clr), .en(en), .pix_data(pix_data),
    .pix_valid(pix_valid), .err_clr(err_clr), .rd_en(rd_en),
    .col_addr(col_addr), .row_addr(row_addr), .r(r), .g(g), .b(b),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .frame_start(frame_start), .line_start(line_start),
    .underflow(underflow)
  );

  always #5 vga_clk = ~vga_clk;

  // Pixel source: echoes the request coordinate after LAT enabled cycles.
  logic [CWA+RWA:0] srcPipe [LAT];
  logic [CWA+RWA:0] srcOut;

  always @(posedge vga_clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) srcPipe[i] <= '0;
    end else if (en) begin
      srcPipe[0] <= {rd_en, col_addr, row_addr};
      for (int i = 1; i < LAT; i++) srcPipe[i] <= srcPipe[i-1];
    end
  end

  assign srcOut   = srcPipe[LAT-1];
  assign pix_data = srcOut[CWA+RWA] ?
                    {8'(srcOut[CWA+RWA-1:RWA]), 8'(srcOut[RWA-1:0]), 8'h5A} : 24'h0;

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        line;
    logic        frame;
    logic        uf;
    logic        syncn;
  } exp_t;

  exp_t expQ[$];
  exp_t lastExp;
  exp_t resetExp;
  exp_t monExp;
  int   n;
  logic expUf;
  int   checks = 0;
  int   passes = 0;

  function automatic logic activeAt(input int q);
    int h, v;
    h = q % HT;
    v = (q / HT) % VT;
    return (h < HA) && (v < VA);
  endfunction

  // Pin values expected for raster position q (negative q = pipeline still holding reset state).
  function automatic exp_t modelAt(input int q, input logic valid, input logic uf);
    exp_t e;
    int   h, v;
    logic act;
    e    = resetExp;
    e.uf = uf;
    if (q >= 0) begin
      h       = q % HT;
      v       = (q / HT) % VT;
      act     = (h < HA) && (v < VA);
      e.rgb   = (act && valid) ? {8'(h), 8'(v), 8'h5A} : 24'h0;
      e.hs    = (h >= HA + HF && h < HA + HF + HSY) ? HSP : ~HSP;
      e.vs    = (v >= VA + VF && v < VA + VF + VSY) ? VSP : ~VSP;
      e.blank = act;
      e.line  = (h == 0);
      e.frame = (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic checkOutput(input exp_t e, input string name);
    exp_t act;
    act = '{rgb: {r, g, b}, hs: hsync_out, vs: vsync_out, blank: vga_blank_n,
            line: line_start, frame: frame_start, uf: underflow, syncn: vga_sync_n};
    checks++;
    if (act === e) passes++;
    else $display("[TB] FAIL %s t=%0t got rgb=%h hs=%b vs=%b bl=%b ls=%b fs=%b uf=%b sn=%b exp rgb=%h hs=%b vs=%b bl=%b ls=%b fs=%b uf=%b sn=%b",
                  name, $time, act.rgb, act.hs, act.vs, act.blank, act.line, act.frame, act.uf, act.syncn,
                  e.rgb, e.hs, e.vs, e.blank, e.line, e.frame, e.uf, e.syncn);
  endtask

  // Drives one negedge per cycle and queues the pin state expected after the following posedge.
  task automatic applyStimulus(input int cycles, input bit holdEn);
    int   q;
    logic newUf;
    for (int i = 0; i < cycles; i++) begin
      @(negedge vga_clk);
      clr       = 1'b0;
      en        = holdEn ? 1'b0 : ($urandom_range(0, 7) != 0);
      pix_valid = ($urandom_range(0, 11) != 0);
      err_clr   = ($urandom_range(0, 39) == 0);
      q = n - (LAT + 1);
      if (en) begin
        newUf   = (q >= 0 && activeAt(q) && !pix_valid) ? 1'b1 : (err_clr ? 1'b0 : expUf);
        lastExp = modelAt(q, pix_valid, newUf);
        n++;
      end else begin
        newUf      = err_clr ? 1'b0 : expUf;
        lastExp.uf = newUf;
      end
      expUf = newUf;
      expQ.push_back(lastExp);
    end
  endtask

  task automatic doReset(input int hold);
    @(negedge vga_clk);
    clr = 1'b1;
    en  = $urandom_range(0, 1) != 0;
    #1;
    checkOutput(resetExp, "asyncReset");
    n       = 0;
    expUf   = 1'b0;
    lastExp = resetExp;
    expQ.push_back(resetExp);
    for (int i = 1; i < hold; i++) begin
      @(negedge vga_clk);
      expQ.push_back(resetExp);
    end
  endtask

  always @(posedge vga_clk) begin
    #1;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput(monExp, "cycle");
    end
  end

  initial begin
    resetExp = '{rgb: 24'h0, hs: ~HSP, vs: ~VSP, blank: 1'b0, line: 1'b0,
                 frame: 1'b0, uf: 1'b0, syncn: 1'b0};
    n       = 0;
    expUf   = 1'b0;
    lastExp = resetExp;
    doReset(3);
    applyStimulus(1400, 1'b0);
    applyStimulus(10, 1'b1);
    applyStimulus(600, 1'b0);
    doReset(2);
    applyStimulus(1200, 1'b0);
    @(posedge vga_clk);
    #2;
    checks++;
    if (expQ.size() == 0) passes++;
    else $display("[TB] FAIL drain got=%0d pending expectations exp=0", expQ.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
